// File: rtl/ivs_cfg_seq.sv
// ivs_cfg_seq
// Command-driven AHB-lite master that programs the IVS register slave.
// Host commands are buffered in a small FIFO and then issued one at a time
// as single-word, non-overlapped AHB transfers (IDLE -> ADDR -> DATA -> RESP).
// Each finished transfer produces a one-cycle response pulse.
//
// Ports
//   hclk, hrst_n        clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready = FIFO not full)
//   cmd_write/addr/wdata  command payload (addr is a 12-bit byte offset)
//   rsp_valid/rdata/err   one-cycle response per completed transfer
//   busy                FIFO non-empty or a transfer in progress
//   err_sticky/err_clr  latched error flag and its clear
//   done_cnt            wrapping completed-transfer counter
//   hsel..hprot         AHB-lite master outputs
//   hready/hresp/hrdata AHB-lite slave returns
module ivs_cfg_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        err_sticky,
  input  logic        err_clr,
  output logic [15:0] done_cnt,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t             state;
  logic               fifo_wr    [FIFO_DEPTH];
  logic [11:0]        fifo_addr  [FIFO_DEPTH];
  logic [31:0]        fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [31:0]        wdata_p0;

  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never frees a slot early.
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state == ST_IDLE) & ~empty;
  assign busy      = ~empty | (state != ST_IDLE);

  // Command storage: payload only, no reset needed.
  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_wr[wr_ptr]    <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state      <= ST_IDLE;
      hsel       <= 1'b0;
      htrans     <= HTRANS_IDLE;
      hwrite     <= 1'b0;
      haddr      <= '0;
      hwdata     <= '0;
      wdata_p0   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      done_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // A new error outranks a simultaneous clear.
      if (rsp_valid && rsp_err) err_sticky <= 1'b1;
      else if (err_clr)         err_sticky <= 1'b0;

      case (state)
        // Stage boundary: FIFO head -> address phase
        ST_IDLE: begin
          if (pop) begin
            hsel     <= 1'b1;
            htrans   <= HTRANS_NONSEQ;
            hwrite   <= fifo_wr[rd_ptr];
            haddr    <= BASE_ADDR + {20'h0, fifo_addr[rd_ptr]};
            wdata_p0 <= fifo_wdata[rd_ptr];
            state    <= ST_ADDR;
          end
        end
        // Stage boundary: address phase -> data phase
        ST_ADDR: begin
          if (hready) begin
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= wdata_p0;
            state  <= ST_DATA;
          end
        end
        // Stage boundary: data phase -> response
        ST_DATA: begin
          if (hready) begin
            rsp_rdata <= hwrite ? 32'h0 : hrdata;
            rsp_err   <= (hresp != 2'b00);
            rsp_valid <= 1'b1;
            done_cnt  <= done_cnt + 16'd1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_cfg_seq.sv
module tb_ivs_cfg_seq;

  logic        hclk;
  logic        hrst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;
  logic [15:0] done_cnt;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  ivs_cfg_seq #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .hclk(hclk), .hrst_n(hrst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr), .done_cnt(done_cnt),
    .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: register file contents plus in-order expected responses.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t        expq[$];
  logic [31:0] ref_mem [1024];
  logic [15:0] exp_done = 16'h0;

  // Slave model knobs and observations.
  logic [31:0] sl_mem [1024];
  int          addr_wait = 0;
  int          data_wait = 0;
  logic        sl_err = 1'b0;
  int          sl_ph = 0;
  int          sl_cnt = 0;
  logic [31:0] sl_addr = 32'h0;
  logic [31:0] sl_hwd = 32'h0;
  logic        sl_wr = 1'b0;
  int          sl_xfers = 0;
  logic [31:0] sl_last_addr = 32'h0;
  logic [31:0] sl_last_wdata = 32'h0;
  logic        stab_bad = 1'b0;
  logic        b2b_bad = 1'b0;
  logic        prev_acc = 1'b0;

  // AHB slave: IVS-like, one mandatory wait in data phase plus configurable extras.
  initial begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    for (int i = 0; i < 1024; i++) sl_mem[i] = 32'h0;
    forever begin
      @(negedge hclk);
      if (!hrst_n) begin
        sl_ph = 0; hready = 1'b1; hresp = 2'b00; prev_acc = 1'b0;
      end else begin
        if (prev_acc && htrans == 2'b10) b2b_bad = 1'b1;
        if (sl_ph == 2 && hready) sl_ph = 0;
        else if (sl_ph == 1 && hready) begin sl_ph = 2; sl_cnt = 0; sl_hwd = hwdata; end
        if (sl_ph == 0 && hsel && htrans == 2'b10) begin
          sl_ph = 1; sl_cnt = 0; sl_addr = haddr; sl_wr = hwrite;
        end
        hready = 1'b1;
        hresp  = 2'b00;
        if (sl_ph == 1) begin
          if (haddr !== sl_addr || htrans !== 2'b10 || hsel !== 1'b1 || hwrite !== sl_wr)
            stab_bad = 1'b1;
          hready = (sl_cnt >= addr_wait);
          sl_cnt++;
        end else if (sl_ph == 2) begin
          if (hwdata !== sl_hwd || htrans !== 2'b00 || hsel !== 1'b0 || haddr !== sl_addr)
            stab_bad = 1'b1;
          if (sl_cnt >= 1 + data_wait) begin
            hresp  = sl_err ? 2'b01 : 2'b00;
            hrdata = sl_mem[sl_addr[11:2]];
            if (sl_wr && !sl_err) sl_mem[sl_addr[11:2]] = hwdata;
            sl_xfers++;
            sl_last_addr  = sl_addr;
            sl_last_wdata = hwdata;
          end else begin
            hready = 1'b0;
          end
          sl_cnt++;
        end
        prev_acc = (htrans == 2'b10) && hready;
      end
    end
  end

  // Response scoreboard.
  exp_t mon_e;
  always @(negedge hclk) begin
    if (hrst_n && rsp_valid) begin
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: queue size %0d required >0", expq.size());
      end
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Offer one command starting at a negedge; returns at the negedge after acceptance
  // with cmd_valid still asserted.
  task automatic push(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      output int waits);
    exp_t e;
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && waits < 200) begin
      @(negedge hclk);
      waits++;
    end
    chk("push_ready", 32'(cmd_ready), 1);
    @(posedge hclk);
    e.err   = sl_err;
    e.rdata = wr ? 32'h0 : ref_mem[a[11:2]];
    if (wr && !sl_err) ref_mem[a[11:2]] = d;
    expq.push_back(e);
    exp_done = exp_done + 16'd1;
    @(negedge hclk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int cyc = 0;
    do begin
      @(negedge hclk);
      cyc++;
    end while (!(rsp_valid && done_cnt == exp_done) && cyc < budget);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
  endtask

  initial begin
    int w;
    int lat;
    int n;
    int pulses;
    logic wr;
    logic [11:0] a;
    logic [31:0] d;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    err_clr   = 1'b0;
    hrst_n    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h104;
    cmd_wdata = 32'hFFFF_FFFF;

    // Reset with a command offered: nothing may be accepted or issued.
    repeat (3) @(negedge hclk);
    chk("rst_hsel", 32'(hsel), 0);
    chk("rst_htrans", 32'(htrans), 0);
    chk("rst_hwrite", 32'(hwrite), 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("const_hsize", 32'(hsize), 2);
    chk("const_hburst", 32'(hburst), 0);
    chk("const_hprot", 32'(hprot), 3);
    cmd_valid = 1'b0;
    hrst_n    = 1'b1;
    @(negedge hclk);
    chk("post_rst_busy", 32'(busy), 0);

    // Single write: latency from push edge to response.
    push(1'b1, 12'h104, 32'hDEADBEEF, w);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge hclk);
      lat++;
      if (lat == 2) begin
        chk("t1_htrans", 32'(htrans), 2);
        chk("t1_haddr", haddr, 32'h104);
        chk("t1_hsel", 32'(hsel), 1);
      end
    end
    chk("t1_latency", lat, 5);
    chk("t1_err", 32'(rsp_err), 0);
    chk("t1_done_cnt", 32'(done_cnt), 1);
    chk("t1_xfers", sl_xfers, 1);
    chk("t1_slave_addr", sl_last_addr, 32'h104);
    chk("t1_slave_wdata", sl_last_wdata, 32'hDEADBEEF);

    // Write then read back the same register.
    @(negedge hclk);
    push(1'b1, 12'h100, 32'h12345678, w);
    push(1'b0, 12'h100, 32'h0, w);
    cmd_valid = 1'b0;
    wait_done(60, "t2");
    chk("t2_readback", rsp_rdata, 32'h12345678);
    chk("t2_no_b2b_nonseq", 32'(b2b_bad), 0);

    // FIFO_DEPTH+2 back-to-back commands with cmd_valid held.
    @(negedge hclk);
    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 12'h100 + 12'(4 * $urandom_range(0, 11));
      d  = $urandom;
      push(wr, a, d, w);
      if (i == 4) chk("t3_ready_full", 32'(cmd_ready), 0);
      if (i == 5) chk("t3_push_wait", w, 2);
    end
    cmd_valid = 1'b0;
    wait_done(150, "t3");
    chk("t3_busy_at_rsp", 32'(busy), 1);
    @(negedge hclk);
    chk("t3_busy_after", 32'(busy), 0);

    // Stretched phases with an error response.
    addr_wait = 3;
    data_wait = 3;
    sl_err    = 1'b1;
    push(1'b1, 12'h108, 32'hAAAA5555, w);
    cmd_valid = 1'b0;
    wait_done(80, "t4a");
    chk("t4_rsp_err", 32'(rsp_err), 1);
    @(negedge hclk);
    chk("t4_sticky_set", 32'(err_sticky), 1);
    chk("t4_stable", 32'(stab_bad), 0);
    err_clr = 1'b1;
    @(negedge hclk);
    err_clr = 1'b0;
    chk("t4_sticky_clr", 32'(err_sticky), 0);
    push(1'b1, 12'h10C, 32'h5555AAAA, w);
    cmd_valid = 1'b0;
    wait_done(80, "t4b");
    err_clr = 1'b1;
    @(negedge hclk);
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(err_sticky), 1);
    sl_err    = 1'b0;
    addr_wait = 0;
    data_wait = 0;

    // Randomized traffic against the reference model.
    @(negedge hclk);
    for (int i = 0; i < 16; i++) begin
      addr_wait = $urandom_range(0, 2);
      data_wait = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = 12'h100 + 12'(4 * $urandom_range(0, 11));
      d  = $urandom;
      push(wr, a, d, w);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge hclk);
      end
    end
    cmd_valid = 1'b0;
    wait_done(600, "rand");
    chk("rand_stable", 32'(stab_bad), 0);
    chk("rand_no_b2b_nonseq", 32'(b2b_bad), 0);
    addr_wait = 0;
    data_wait = 2;

    // Reset in the data phase of a read with another read queued.
    @(negedge hclk);
    push(1'b0, 12'h104, 32'h0, w);
    push(1'b0, 12'h108, 32'h0, w);
    cmd_valid = 1'b0;
    n = 0;
    while (!hsel && n < 20) begin
      @(negedge hclk);
      n++;
    end
    @(negedge hclk);
    #1 hrst_n = 1'b0;
    expq.delete();
    exp_done = 16'h0;
    #1;
    chk("t5_htrans", 32'(htrans), 0);
    chk("t5_hsel", 32'(hsel), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cmd_ready", 32'(cmd_ready), 1);
    chk("t5_done_cnt", 32'(done_cnt), 0);
    @(negedge hclk);
    @(negedge hclk);
    hrst_n = 1'b1;
    data_wait = 0;
    pulses = 0;
    repeat (10) begin
      @(negedge hclk);
      if (rsp_valid) pulses++;
    end
    chk("t5_no_rsp", pulses, 0);
    d = $urandom;
    push(1'b1, 12'h110, d, w);
    cmd_valid = 1'b0;
    wait_done(20, "t5");
    chk("t5_slave_wdata", sl_last_wdata, d);
    chk("t5_rsp_err", 32'(rsp_err), 0);

    // done_cnt wrap from 0xFFFF.
    @(negedge hclk);
    force dut.done_cnt = 16'hFFFF;
    @(negedge hclk);
    release dut.done_cnt;
    @(negedge hclk);
    chk("wrap_preload", 32'(done_cnt), 32'hFFFF);
    exp_done = 16'hFFFF;
    push(1'b0, 12'h110, 32'h0, w);
    cmd_valid = 1'b0;
    wait_done(20, "wrap");
    chk("wrap_zero", 32'(done_cnt), 0);

    repeat (3) @(negedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
